// File: rtl/apb_pkg.sv
// Shared APB types: requester state encoding and default bus widths used by master and slaves.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts consecutive ACCESS wait cycles; expired_o fires combinationally on the LIMIT-th stalled cycle.
module apb_wait_timer #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q holds the stalls already seen, so the current stall is number count_q+1.
  assign expired_o = en_i && (count_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/apb_master.sv
// APB requester: single command in, IDLE/SETUP/ACCESS sequence out, one-cycle response pulse back.
// Build option APB_TIMEOUT_EN aborts an ACCESS phase stalled for TIMEOUT_CYCLES and flags rsp_err_o.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              psel_o,
  output logic              pen_o,
  output logic              pwrite_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic              pready_i,
  input  logic [DATA_W-1:0] prdata_i
);

  apb_state_e state_q, state_d;

  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;

  logic accept;
  logic complete;
  logic abort;
  logic timeout_expired;

`ifdef APB_TIMEOUT_EN
  apb_wait_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .clear_i  (accept),
    .en_i     ((state_q == ACCESS) && !pready_i),
    .expired_o(timeout_expired)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout_expired    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_ready_o = 1'b0;
    psel_o      = 1'b0;
    pen_o       = 1'b0;
    complete    = 1'b0;
    abort       = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) state_d = SETUP;
      end
      SETUP: begin
        psel_o  = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        psel_o = 1'b1;
        pen_o  = 1'b1;
        if (pready_i) begin
          // Completing cycle doubles as an accept slot for back-to-back commands.
          complete    = 1'b1;
          cmd_ready_o = 1'b1;
          state_d     = cmd_valid_i ? SETUP : IDLE;
        end else if (timeout_expired) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = cmd_valid_i && cmd_ready_o;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
    end else if (accept) begin
      pwrite_q <= cmd_write_i;
      paddr_q  <= cmd_addr_i;
      // Reads leave pwdata untouched so the write bus only toggles for writes.
      if (cmd_write_i) pwdata_q <= cmd_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= complete || abort;
      rsp_err_q   <= abort;
      if (complete) begin
        rsp_rdata_q <= pwrite_q ? '0 : prdata_i;
      end else if (abort) begin
        rsp_rdata_q <= '0;
      end
    end
  end

  assign pwrite_o    = pwrite_q;
  assign paddr_o     = paddr_q;
  assign pwdata_o    = pwdata_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed + randomized bench for apb_master; the timeout abort case is exercised when APB_TIMEOUT_EN is defined.
module tb_apb_master;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        psel;
  logic        pen;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pready;
  logic [31:0] prdata;

  apb_master #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i      (clk),
    .reset_ni   (reset_n),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_write_i(cmd_write),
    .cmd_addr_i (cmd_addr),
    .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid),
    .rsp_rdata_o(rsp_rdata),
    .rsp_err_o  (rsp_err),
    .psel_o     (psel),
    .pen_o      (pen),
    .pwrite_o   (pwrite),
    .paddr_o    (paddr),
    .pwdata_o   (pwdata),
    .pready_i   (pready),
    .prdata_i   (prdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Transaction-level model: slave memory, the command on the bus, and the response owed next cycle.
  logic [31:0] mem [logic [31:0]];
  logic        cur_write;
  logic [31:0] cur_addr;
  logic [31:0] cur_pwdata;
  logic        nxt_write;
  logic [31:0] nxt_addr;
  logic [31:0] nxt_wdata;
  logic        pend_rsp;
  logic [31:0] pend_rdata;
  logic        pend_err;
  logic [31:0] last_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] slave_read(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], 16'hC0DE};
  endfunction

  task automatic model_reset();
    cur_write  = 1'b0;
    cur_addr   = '0;
    cur_pwdata = '0;
    pend_rsp   = 1'b0;
    pend_rdata = '0;
    pend_err   = 1'b0;
    last_rdata = '0;
  endtask

  task automatic take_nxt();
    cur_write = nxt_write;
    cur_addr  = nxt_addr;
    if (nxt_write) cur_pwdata = nxt_wdata;
  endtask

  task automatic drive_nxt();
    cmd_valid = 1'b1;
    cmd_write = nxt_write;
    cmd_addr  = nxt_addr;
    cmd_wdata = nxt_wdata;
  endtask

  task automatic gen_nxt();
    nxt_write = 1'($urandom % 2);
    nxt_addr  = 32'($urandom % 8) << 2;
    nxt_wdata = $urandom;
  endtask

  // Junk command offered while the master is busy; it must never be captured.
  task automatic drive_junk();
    cmd_valid = 1'($urandom % 2);
    cmd_write = 1'($urandom % 2);
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
  endtask

  // Inputs for this cycle are already set; check every output against the model.
  task automatic step(input logic exp_psel, input logic exp_pen, input logic exp_rdy);
    #1;
    chk("psel", psel, exp_psel);
    chk("pen", pen, exp_pen);
    chk("cmd_ready", cmd_ready, exp_rdy);
    chk("rsp_valid", rsp_valid, pend_rsp);
    chk("rsp_err", rsp_err, pend_rsp ? pend_err : 1'b0);
    chk("rsp_rdata", rsp_rdata, pend_rsp ? pend_rdata : last_rdata);
    if (exp_psel) begin
      chk("paddr", paddr, cur_addr);
      chk("pwrite", pwrite, cur_write);
      chk("pwdata", pwdata, cur_pwdata);
    end
    if (pend_rsp) last_rdata = pend_rdata;
    pend_rsp = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      pready    = 1'($urandom % 2);
      step(1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic accept_from_idle();
    @(negedge clk);
    pready = 1'($urandom % 2);
    drive_nxt();
    step(1'b0, 1'b0, 1'b1);
    take_nxt();
  endtask

  // Runs SETUP, waits ACCESS stalls and the completing cycle of the current command.
  task automatic xfer(input int waits, input logic chain);
    logic [31:0] rd;
    @(negedge clk);
    pready = 1'($urandom % 2);
    drive_junk();
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      pready = 1'b0;
      prdata = $urandom;
      drive_junk();
      step(1'b1, 1'b1, 1'b0);
    end
    @(negedge clk);
    pready = 1'b1;
    rd     = cur_write ? 32'h0 : slave_read(cur_addr);
    prdata = cur_write ? $urandom : rd;
    if (chain) drive_nxt();
    else cmd_valid = 1'b0;
    step(1'b1, 1'b1, 1'b1);
    if (cur_write) mem[cur_addr] = cur_pwdata;
    pend_rsp   = 1'b1;
    pend_rdata = rd;
    pend_err   = 1'b0;
    if (chain) take_nxt();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_psel"}, psel, 1'b0);
    chk({tag, "_pen"}, pen, 1'b0);
    chk({tag, "_pwrite"}, pwrite, 1'b0);
    chk({tag, "_paddr"}, paddr, 32'h0);
    chk({tag, "_pwdata"}, pwdata, 32'h0);
    chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    chk({tag, "_rsp_err"}, rsp_err, 1'b0);
  endtask

  initial begin
    logic chain;
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    pready    = 1'b0;
    prdata    = '0;
    model_reset();
    mem[32'h8] = 32'h12345678;
    #12;
    chk_all_zero("reset");
    chk("reset_cmd_ready", cmd_ready, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    idle_cycles(2);

    // Single write, zero wait states.
    nxt_write = 1'b1; nxt_addr = 32'h4; nxt_wdata = 32'hDEADBEEF;
    accept_from_idle();
    xfer(0, 1'b0);
    idle_cycles(1);

    // Single read with two wait states.
    nxt_write = 1'b0; nxt_addr = 32'h8; nxt_wdata = 32'h0BAD0BAD;
    accept_from_idle();
    xfer(2, 1'b0);
    idle_cycles(1);
    chk("read_data_held", rsp_rdata, 32'h12345678);

    // Back-to-back write then read of the same address.
    nxt_write = 1'b1; nxt_addr = 32'h1; nxt_wdata = 32'hA5A5_0001;
    accept_from_idle();
    nxt_write = 1'b0; nxt_addr = 32'h1; nxt_wdata = 32'h0;
    xfer(0, 1'b1);
    xfer(1, 1'b0);
    idle_cycles(1);

    // Reset while a read sits in ACCESS: outputs clear at once, no response follows.
    nxt_write = 1'b0; nxt_addr = 32'h8; nxt_wdata = 32'h0;
    accept_from_idle();
    @(negedge clk); pready = 1'b0; cmd_valid = 1'b0; step(1'b1, 1'b0, 1'b0);
    @(negedge clk); pready = 1'b0; step(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    idle_cycles(2);
    nxt_write = 1'b0; nxt_addr = 32'h4; nxt_wdata = 32'h0;
    accept_from_idle();
    xfer(0, 1'b0);
    idle_cycles(1);

    // Long stall: abort under the timeout build, indefinite wait otherwise.
    nxt_write = 1'b0; nxt_addr = 32'h10; nxt_wdata = 32'h0;
    accept_from_idle();
`ifdef APB_TIMEOUT_EN
    @(negedge clk); pready = 1'b0; cmd_valid = 1'b0; step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); pready = 1'b0; drive_junk(); step(1'b1, 1'b1, 1'b0);
    end
    pend_rsp = 1'b1; pend_rdata = 32'h0; pend_err = 1'b1;
    @(negedge clk); cmd_valid = 1'b0; step(1'b0, 1'b0, 1'b1);
`else
    xfer(20, 1'b0);
`endif
    idle_cycles(1);

    // Randomized mix of reads/writes, wait states and back-to-back chaining.
    gen_nxt();
    accept_from_idle();
    for (int i = 0; i < 40; i++) begin
      chain = (i < 39) && 1'($urandom % 2);
      if (chain) gen_nxt();
      xfer(int'($urandom % 4), chain);
      if (!chain) begin
        idle_cycles(int'($urandom % 2));
        if (i < 39) begin
          gen_nxt();
          accept_from_idle();
        end
      end
    end
    idle_cycles(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
